// File: rtl/omdc_counter_bank.sv
// omdc_counter_bank: counter datapath for the OMDC FIFO dataflow controller.
// Window-column, stride, columns-in-FIFO, output-row and channel counts, plus
// the flags that steer the state machine (Eqcw, Eqst, Eqcif, NewCh, Finish).
//
// Ports:
//   Clk / Reset                : rising-edge clock, synchronous active-low reset
//   Cfg_Kw/Stride/Img_W        : terminal values of the cw/st/cif counts
//   Cfg_Out_Rows/Cfg_Channels  : rows per channel, channel count
//   {Eqcw,Eqst,Crow,Eqcif}_En/_Reset/_load1 : per-counter strobes
//   Clear_All                  : clears every counter including channel
//   Flag_* / Finish_Routine    : compares of registered counts only
//   Row_Index / Channel_Index  : current crow / ch counts
//   Error                      : sticky overrun flag (OMDC_COUNTER_BANK_ERR_EN)
//
// Optional feature macro: OMDC_COUNTER_BANK_ERR_EN adds the Error output.
module omdc_counter_bank #(
    parameter int CW_W  = 8,
    parameter int COL_W = 10,
    parameter int ROW_W = 10,
    parameter int CH_W  = 8
) (
    input  logic             OMDC_COUNTER_BANK_Clk,
    input  logic             OMDC_COUNTER_BANK_Reset,
    input  logic [CW_W-1:0]  OMDC_COUNTER_BANK_Cfg_Kw,
    input  logic [CW_W-1:0]  OMDC_COUNTER_BANK_Cfg_Stride,
    input  logic [COL_W-1:0] OMDC_COUNTER_BANK_Cfg_Img_W,
    input  logic [ROW_W-1:0] OMDC_COUNTER_BANK_Cfg_Out_Rows,
    input  logic [CH_W-1:0]  OMDC_COUNTER_BANK_Cfg_Channels,
    input  logic             OMDC_COUNTER_BANK_Eqcw_En,
    input  logic             OMDC_COUNTER_BANK_Eqst_En,
    input  logic             OMDC_COUNTER_BANK_Crow_En,
    input  logic             OMDC_COUNTER_BANK_Eqcif_En,
    input  logic             OMDC_COUNTER_BANK_Eqcw_Reset,
    input  logic             OMDC_COUNTER_BANK_Eqst_Reset,
    input  logic             OMDC_COUNTER_BANK_Crow_Reset,
    input  logic             OMDC_COUNTER_BANK_Eqcif_Reset,
    input  logic             OMDC_COUNTER_BANK_Eqcw_load1,
    input  logic             OMDC_COUNTER_BANK_Eqst_load1,
    input  logic             OMDC_COUNTER_BANK_Crow_load1,
    input  logic             OMDC_COUNTER_BANK_Eqcif_load1,
    input  logic             OMDC_COUNTER_BANK_Clear_All,
    output logic             OMDC_COUNTER_BANK_Flag_Eqcw,
    output logic             OMDC_COUNTER_BANK_Flag_Eqst,
    output logic             OMDC_COUNTER_BANK_Flag_Eqcif,
    output logic             OMDC_COUNTER_BANK_Flag_NewCh,
    output logic             OMDC_COUNTER_BANK_Finish_Routine,
    output logic [ROW_W-1:0] OMDC_COUNTER_BANK_Row_Index,
    output logic [CH_W-1:0]  OMDC_COUNTER_BANK_Channel_Index
`ifdef OMDC_COUNTER_BANK_ERR_EN
    ,
    output logic             OMDC_COUNTER_BANK_Error
`endif
);

    logic [CW_W-1:0]  cw_cnt;
    logic [CW_W-1:0]  st_cnt;
    logic [COL_W-1:0] cif_cnt;
    logic [ROW_W-1:0] crow_cnt;
    logic [CH_W-1:0]  ch_cnt;
    logic             ch_inc;

    assign OMDC_COUNTER_BANK_Flag_Eqcw  = (cw_cnt == OMDC_COUNTER_BANK_Cfg_Kw);
    assign OMDC_COUNTER_BANK_Flag_Eqst  = (st_cnt == OMDC_COUNTER_BANK_Cfg_Stride);
    assign OMDC_COUNTER_BANK_Flag_Eqcif = (cif_cnt == OMDC_COUNTER_BANK_Cfg_Img_W);
    assign OMDC_COUNTER_BANK_Flag_NewCh = (crow_cnt == OMDC_COUNTER_BANK_Cfg_Out_Rows);
    assign OMDC_COUNTER_BANK_Finish_Routine =
        (ch_cnt == OMDC_COUNTER_BANK_Cfg_Channels) &&
        (OMDC_COUNTER_BANK_Cfg_Channels != '0);
    assign OMDC_COUNTER_BANK_Row_Index     = crow_cnt;
    assign OMDC_COUNTER_BANK_Channel_Index = ch_cnt;

    // A row reload taken while the row count sits at its terminal value
    // starts a new channel; the channel count parks at Cfg_Channels.
    assign ch_inc = OMDC_COUNTER_BANK_Crow_load1 &
                    OMDC_COUNTER_BANK_Crow_Reset &
                    ~OMDC_COUNTER_BANK_Clear_All &
                    OMDC_COUNTER_BANK_Flag_NewCh &
                    (ch_cnt != OMDC_COUNTER_BANK_Cfg_Channels);

    always_ff @(posedge OMDC_COUNTER_BANK_Clk) begin
        if (!OMDC_COUNTER_BANK_Reset)
            cw_cnt <= '0;
        else if (OMDC_COUNTER_BANK_Clear_All)
            cw_cnt <= '0;
        else if (!OMDC_COUNTER_BANK_Eqcw_Reset)
            cw_cnt <= '0;
        else if (OMDC_COUNTER_BANK_Eqcw_load1)
            cw_cnt <= CW_W'(1);
        else if (OMDC_COUNTER_BANK_Eqcw_En)
            cw_cnt <= cw_cnt + 1'b1;
    end

    always_ff @(posedge OMDC_COUNTER_BANK_Clk) begin
        if (!OMDC_COUNTER_BANK_Reset)
            st_cnt <= '0;
        else if (OMDC_COUNTER_BANK_Clear_All)
            st_cnt <= '0;
        else if (!OMDC_COUNTER_BANK_Eqst_Reset)
            st_cnt <= '0;
        else if (OMDC_COUNTER_BANK_Eqst_load1)
            st_cnt <= CW_W'(1);
        else if (OMDC_COUNTER_BANK_Eqst_En)
            st_cnt <= st_cnt + 1'b1;
    end

    always_ff @(posedge OMDC_COUNTER_BANK_Clk) begin
        if (!OMDC_COUNTER_BANK_Reset)
            cif_cnt <= '0;
        else if (OMDC_COUNTER_BANK_Clear_All)
            cif_cnt <= '0;
        else if (!OMDC_COUNTER_BANK_Eqcif_Reset)
            cif_cnt <= '0;
        else if (OMDC_COUNTER_BANK_Eqcif_load1)
            cif_cnt <= COL_W'(1);
        else if (OMDC_COUNTER_BANK_Eqcif_En)
            cif_cnt <= cif_cnt + 1'b1;
    end

    always_ff @(posedge OMDC_COUNTER_BANK_Clk) begin
        if (!OMDC_COUNTER_BANK_Reset)
            crow_cnt <= '0;
        else if (OMDC_COUNTER_BANK_Clear_All)
            crow_cnt <= '0;
        else if (!OMDC_COUNTER_BANK_Crow_Reset)
            crow_cnt <= '0;
        else if (OMDC_COUNTER_BANK_Crow_load1)
            crow_cnt <= ROW_W'(1);
        else if (OMDC_COUNTER_BANK_Crow_En)
            crow_cnt <= crow_cnt + 1'b1;
    end

    always_ff @(posedge OMDC_COUNTER_BANK_Clk) begin
        if (!OMDC_COUNTER_BANK_Reset)
            ch_cnt <= '0;
        else if (OMDC_COUNTER_BANK_Clear_All)
            ch_cnt <= '0;
        else if (ch_inc)
            ch_cnt <= ch_cnt + 1'b1;
    end

`ifdef OMDC_COUNTER_BANK_ERR_EN
    logic err_q;
    logic overrun;

    // An increment actually taken (no clear, no load) while already at
    // the terminal value, or a channel step out of the all-ones count.
    assign overrun =
        (OMDC_COUNTER_BANK_Eqcw_Reset & ~OMDC_COUNTER_BANK_Eqcw_load1 &
         OMDC_COUNTER_BANK_Eqcw_En & OMDC_COUNTER_BANK_Flag_Eqcw) |
        (OMDC_COUNTER_BANK_Eqst_Reset & ~OMDC_COUNTER_BANK_Eqst_load1 &
         OMDC_COUNTER_BANK_Eqst_En & OMDC_COUNTER_BANK_Flag_Eqst) |
        (OMDC_COUNTER_BANK_Eqcif_Reset & ~OMDC_COUNTER_BANK_Eqcif_load1 &
         OMDC_COUNTER_BANK_Eqcif_En & OMDC_COUNTER_BANK_Flag_Eqcif) |
        (OMDC_COUNTER_BANK_Crow_Reset & ~OMDC_COUNTER_BANK_Crow_load1 &
         OMDC_COUNTER_BANK_Crow_En & OMDC_COUNTER_BANK_Flag_NewCh) |
        (ch_inc & (ch_cnt == '1));

    always_ff @(posedge OMDC_COUNTER_BANK_Clk) begin
        if (!OMDC_COUNTER_BANK_Reset)
            err_q <= 1'b0;
        else if (OMDC_COUNTER_BANK_Clear_All)
            err_q <= 1'b0;
        else if (overrun)
            err_q <= 1'b1;
    end

    assign OMDC_COUNTER_BANK_Error = err_q;
`endif

endmodule

// File: tb/tb_omdc_counter_bank.sv
// tb_omdc_counter_bank: directed literal checks plus randomized strobes
// compared every cycle against a counting model of the counter bank.
module tb_omdc_counter_bank;

    logic       clk;
    logic       rst_n;
    logic [7:0] kw, stride;
    logic [9:0] img_w, rows;
    logic [7:0] chans;
    logic       cw_en, st_en, crow_en, cif_en;
    logic       cw_rn, st_rn, crow_rn, cif_rn;
    logic       cw_ld, st_ld, crow_ld, cif_ld;
    logic       clr;
    logic       f_cw, f_st, f_cif, f_newch, fin;
    logic [9:0] row_idx;
    logic [7:0] ch_idx;
    logic       err;

    int checks = 0;
    int errors = 0;

    int m_cw, m_st, m_cif, m_crow, m_ch;
    bit m_err;

    omdc_counter_bank dut (
        .OMDC_COUNTER_BANK_Clk(clk),
        .OMDC_COUNTER_BANK_Reset(rst_n),
        .OMDC_COUNTER_BANK_Cfg_Kw(kw),
        .OMDC_COUNTER_BANK_Cfg_Stride(stride),
        .OMDC_COUNTER_BANK_Cfg_Img_W(img_w),
        .OMDC_COUNTER_BANK_Cfg_Out_Rows(rows),
        .OMDC_COUNTER_BANK_Cfg_Channels(chans),
        .OMDC_COUNTER_BANK_Eqcw_En(cw_en),
        .OMDC_COUNTER_BANK_Eqst_En(st_en),
        .OMDC_COUNTER_BANK_Crow_En(crow_en),
        .OMDC_COUNTER_BANK_Eqcif_En(cif_en),
        .OMDC_COUNTER_BANK_Eqcw_Reset(cw_rn),
        .OMDC_COUNTER_BANK_Eqst_Reset(st_rn),
        .OMDC_COUNTER_BANK_Crow_Reset(crow_rn),
        .OMDC_COUNTER_BANK_Eqcif_Reset(cif_rn),
        .OMDC_COUNTER_BANK_Eqcw_load1(cw_ld),
        .OMDC_COUNTER_BANK_Eqst_load1(st_ld),
        .OMDC_COUNTER_BANK_Crow_load1(crow_ld),
        .OMDC_COUNTER_BANK_Eqcif_load1(cif_ld),
        .OMDC_COUNTER_BANK_Clear_All(clr),
        .OMDC_COUNTER_BANK_Flag_Eqcw(f_cw),
        .OMDC_COUNTER_BANK_Flag_Eqst(f_st),
        .OMDC_COUNTER_BANK_Flag_Eqcif(f_cif),
        .OMDC_COUNTER_BANK_Flag_NewCh(f_newch),
        .OMDC_COUNTER_BANK_Finish_Routine(fin),
        .OMDC_COUNTER_BANK_Row_Index(row_idx),
        .OMDC_COUNTER_BANK_Channel_Index(ch_idx)
`ifdef OMDC_COUNTER_BANK_ERR_EN
        ,
        .OMDC_COUNTER_BANK_Error(err)
`endif
    );

`ifndef OMDC_COUNTER_BANK_ERR_EN
    assign err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Next value of a generic counter: clear, else load 1, else step.
    function automatic int nxt(int c, bit rn, bit ld, bit en, int w);
        if (!rn) return 0;
        if (ld) return 1;
        if (en) return (c + 1) % (1 << w);
        return c;
    endfunction

    function automatic bit ovr(int c, int t, bit rn, bit ld, bit en);
        return rn && !ld && en && (c == t);
    endfunction

    task automatic model_step();
        bit newch;
        bit ovf;
        if (!rst_n || clr) begin
            m_cw = 0; m_st = 0; m_cif = 0; m_crow = 0; m_ch = 0;
            m_err = 0;
            return;
        end
        newch = (m_crow == int'(rows));
        ovf = ovr(m_cw, int'(kw), cw_rn, cw_ld, cw_en) |
              ovr(m_st, int'(stride), st_rn, st_ld, st_en) |
              ovr(m_cif, int'(img_w), cif_rn, cif_ld, cif_en) |
              ovr(m_crow, int'(rows), crow_rn, crow_ld, crow_en);
        if (crow_ld && crow_rn && newch && m_ch != int'(chans)) begin
            if (m_ch == 255) ovf = 1;
            m_ch = (m_ch + 1) % 256;
        end
        m_cw   = nxt(m_cw, cw_rn, cw_ld, cw_en, 8);
        m_st   = nxt(m_st, st_rn, st_ld, st_en, 8);
        m_cif  = nxt(m_cif, cif_rn, cif_ld, cif_en, 10);
        m_crow = nxt(m_crow, crow_rn, crow_ld, crow_en, 10);
        if (ovf) m_err = 1;
    endtask

    task automatic compare();
        chk("eqcw", 32'(f_cw), 32'(m_cw == int'(kw)));
        chk("eqst", 32'(f_st), 32'(m_st == int'(stride)));
        chk("eqcif", 32'(f_cif), 32'(m_cif == int'(img_w)));
        chk("newch", 32'(f_newch), 32'(m_crow == int'(rows)));
        chk("finish", 32'(fin),
            32'(m_ch == int'(chans) && chans != 0));
        chk("row_idx", 32'(row_idx), 32'(m_crow));
        chk("ch_idx", 32'(ch_idx), 32'(m_ch));
`ifdef OMDC_COUNTER_BANK_ERR_EN
        chk("error", 32'(err), 32'(m_err));
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        rst_n = 1; clr = 0;
        cw_en = 0; st_en = 0; crow_en = 0; cif_en = 0;
        cw_rn = 1; st_rn = 1; crow_rn = 1; cif_rn = 1;
        cw_ld = 0; st_ld = 0; crow_ld = 0; cif_ld = 0;
    endtask

    task automatic rand_strobes();
        rst_n   = ($urandom_range(0, 63) != 0);
        clr     = ($urandom_range(0, 47) == 0);
        cw_en   = 1'($urandom_range(0, 1));
        st_en   = 1'($urandom_range(0, 1));
        crow_en = 1'($urandom_range(0, 1));
        cif_en  = 1'($urandom_range(0, 1));
        cw_rn   = ($urandom_range(0, 9) != 0);
        st_rn   = ($urandom_range(0, 9) != 0);
        crow_rn = ($urandom_range(0, 9) != 0);
        cif_rn  = ($urandom_range(0, 9) != 0);
        cw_ld   = ($urandom_range(0, 3) == 0);
        st_ld   = ($urandom_range(0, 3) == 0);
        crow_ld = ($urandom_range(0, 2) == 0);
        cif_ld  = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        m_cw = 0; m_st = 0; m_cif = 0; m_crow = 0; m_ch = 0; m_err = 0;
        kw = 8'd3; stride = 8'd0; img_w = 10'd0;
        rows = 10'd2; chans = 8'd2;

        // Reset with random strobes
        rand_strobes();
        rst_n = 0;
        tick();
        chk("rst_eqcw", 32'(f_cw), 32'd0);
        chk("rst_finish", 32'(fin), 32'd0);
        chk("rst_eqst_zero_term", 32'(f_st), 32'd1);
        chk("rst_row", 32'(row_idx), 32'd0);
        chk("rst_ch", 32'(ch_idx), 32'd0);

        // Window column count to Kw=3, then reload
        idle();
        cw_en = 1;
        tick();
        tick();
        chk("cw2_flag", 32'(f_cw), 32'd0);
        tick();
        chk("cw3_flag", 32'(f_cw), 32'd1);
        cw_en = 0; cw_ld = 1;
        tick();
        chk("cw_reload_flag", 32'(f_cw), 32'd0);

        // Clear beats load beats enable
        idle();
        img_w = 10'd0;
        cif_rn = 0; cif_ld = 1; cif_en = 1;
        tick();
        chk("cif_clear_wins", 32'(f_cif), 32'd1);
        cif_rn = 1;
        tick();
        chk("cif_load_wins", 32'(f_cif), 32'd0);
        idle();
        img_w = 10'd1;
        #1;
        chk("cif_cfg_comb", 32'(f_cif), 32'd1);

        // Rows into channels: Out_Rows=2, Channels=2
        rows = 10'd2; chans = 8'd2;
        crow_en = 1;
        tick();
        tick();
        chk("crow2_row", 32'(row_idx), 32'd2);
        chk("crow2_newch", 32'(f_newch), 32'd1);
        crow_en = 0; crow_ld = 1;
        tick();
        chk("ch1_row", 32'(row_idx), 32'd1);
        chk("ch1_ch", 32'(ch_idx), 32'd1);
        crow_ld = 0; crow_en = 1;
        tick();
        crow_en = 0; crow_ld = 1;
        tick();
        chk("ch2_ch", 32'(ch_idx), 32'd2);
        chk("ch2_finish", 32'(fin), 32'd1);
        crow_ld = 0; crow_en = 1;
        tick();
        crow_en = 0; crow_ld = 1;
        tick();
        chk("ch_hold_ch", 32'(ch_idx), 32'd2);
        chk("ch_hold_row", 32'(row_idx), 32'd1);

        // Clear_All drops the finished routine
        idle();
        clr = 1;
        tick();
        chk("clr_ch", 32'(ch_idx), 32'd0);
        chk("clr_row", 32'(row_idx), 32'd0);
        chk("clr_finish", 32'(fin), 32'd0);

`ifdef OMDC_COUNTER_BANK_ERR_EN
        // Stride overrun sets the sticky error
        idle();
        stride = 8'd2;
        st_en = 1;
        tick();
        tick();
        chk("err_before", 32'(err), 32'd0);
        tick();
        chk("err_set", 32'(err), 32'd1);
        idle();
        tick();
        tick();
        chk("err_sticky", 32'(err), 32'd1);
        clr = 1;
        tick();
        chk("err_clr", 32'(err), 32'd0);
`endif

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                kw     = 8'($urandom_range(0, 4));
                stride = 8'($urandom_range(0, 3));
                img_w  = 10'($urandom_range(0, 5));
                rows   = 10'($urandom_range(0, 3));
                chans  = 8'($urandom_range(0, 3));
            end
            rand_strobes();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/omdc_counter_bank.md
Name: omdc_counter_bank

Overview:
Counter datapath paired with the on-chip FIFO dataflow controller state machine. It turns the state machine's per-counter enable, clear and load-1 strobes into the window-column, stride, columns-in-FIFO, output-row and channel counts. From those counts it produces the flags that drive the state machine: Eqcw, Eqst, Eqcif, NewCh and Finish_Routine. The block is pure sequential counters with register-derived flags, so no combinational path runs from any control strobe to any flag.

Parameters:
CW_W, 8, width of window-column and stride counters and of Cfg_Kw/Cfg_Stride
COL_W, 10, width of columns-in-FIFO counter and Cfg_Img_W
ROW_W, 10, width of output-row counter and Cfg_Out_Rows
CH_W, 8, width of channel counter and Cfg_Channels

Ports:
OMDC_COUNTER_BANK_Clk  in  1  clock, rising edge
OMDC_COUNTER_BANK_Reset  in  1  synchronous, active-low reset
OMDC_COUNTER_BANK_Cfg_Kw  in  CW_W  terminal value of the window-column count
OMDC_COUNTER_BANK_Cfg_Stride  in  CW_W  terminal value of the stride count
OMDC_COUNTER_BANK_Cfg_Img_W  in  COL_W  terminal value of the columns-in-FIFO count
OMDC_COUNTER_BANK_Cfg_Out_Rows  in  ROW_W  output rows per channel
OMDC_COUNTER_BANK_Cfg_Channels  in  CH_W  number of channels
OMDC_COUNTER_BANK_{Eqcw,Eqst,Crow,Eqcif}_En  in  1 each  increment enable
OMDC_COUNTER_BANK_{Eqcw,Eqst,Crow,Eqcif}_Reset  in  1 each  active-low clear (1 = run)
OMDC_COUNTER_BANK_{Eqcw,Eqst,Crow,Eqcif}_load1  in  1 each  load value 1
OMDC_COUNTER_BANK_Clear_All  in  1  synchronous clear of all counters, including channel
OMDC_COUNTER_BANK_Flag_Eqcw  out  1  cw_cnt == Cfg_Kw
OMDC_COUNTER_BANK_Flag_Eqst  out  1  st_cnt == Cfg_Stride
OMDC_COUNTER_BANK_Flag_Eqcif  out  1  cif_cnt == Cfg_Img_W
OMDC_COUNTER_BANK_Flag_NewCh  out  1  crow_cnt == Cfg_Out_Rows
OMDC_COUNTER_BANK_Finish_Routine  out  1  ch_cnt == Cfg_Channels and Cfg_Channels != 0
OMDC_COUNTER_BANK_Row_Index  out  ROW_W  crow_cnt, for address generation
OMDC_COUNTER_BANK_Channel_Index  out  CH_W  ch_cnt

Behaviour:
- Reset: when Reset = 0 at a clock edge, every counter (cw, st, cif, crow, ch) becomes 0 and the error register (if compiled in) becomes 0. All flags then evaluate from zero counts.
- Priority, per counter and per edge, highest first:
  - module Reset low
  - Clear_All high -> 0
  - local *_Reset low -> 0
  - *_load1 high -> 1
  - *_En high -> count + 1
  - otherwise hold
- Increment wraps modulo 2^width; no saturation.
- Flags and Finish_Routine are combinational compares of registered counts only, valid the cycle after the updating edge. They never depend on En, load1 or *_Reset.
- Channel counter:
  - Increments on an edge where Crow_load1 = 1, Crow_Reset = 1, Clear_All = 0 and Flag_NewCh = 1 (the row count wraps into a new channel).
  - Cleared only by module reset or Clear_All.
  - Holds once it reaches Cfg_Channels; further qualifying events are ignored.
- Flag_NewCh compares the pre-edge crow_cnt. The channel increment and the crow reload to 1 therefore happen on the same edge.
- Simultaneous *_Reset low and load1 high: clear wins, count = 0.
- Simultaneous load1 and En: load wins, count = 1.
- Cfg_* inputs must be stable while any En is high. A change applies to the flags immediately (combinational), with no re-latching.
- Terminal value 0: the flag is asserted directly after a clear. This is legal for Cfg_Kw, Cfg_Stride and Cfg_Img_W.
- Reset mid-operation: all counts return to 0 on that edge, whatever the strobes are doing.

Optional Feature:
Macro OMDC_COUNTER_BANK_ERR_EN.
- Defined: adds output OMDC_COUNTER_BANK_Error (1 bit, sticky).
  - Set on any edge where a counter increments while its flag is already high (overrun past its terminal value), or where the channel counter would wrap.
  - Cleared only by module reset or Clear_All.
- Undefined: no Error port, and no overrun-detection logic is synthesized.

Test Plan:
- Reset low 1 cycle, all strobes random -> all counts 0 the next cycle. Flags: Eqcw=0 with Cfg_Kw=3; Finish_Routine=0 with Cfg_Channels=2.
- Cfg_Kw=3, Eqcw_Reset=1, Eqcw_En=1 for 3 cycles -> cw_cnt 1,2,3; Flag_Eqcw high in the cycle after the third edge. Eqcw_load1=1 the next edge -> cw_cnt=1, flag low.
- Eqcif_Reset=0, Eqcif_load1=1, Eqcif_En=1 on the same edge -> cif_cnt=0 (clear wins). Then load1=1 with En=1 -> cif_cnt=1.
- Cfg_Out_Rows=2, Cfg_Channels=2: Crow_En pulses to reach crow=2, then Crow_load1 -> crow=1 and ch=1. Repeat -> ch=2 and Finish_Routine=1. A further NewCh reload -> ch stays 2.
- Clear_All pulse with Finish_Routine=1 -> ch=0, crow=0, Finish_Routine=0 the next cycle.
- With OMDC_COUNTER_BANK_ERR_EN defined: Cfg_Stride=2, Eqst_En high for 3 cycles -> Error=1 after the third edge and stays 1 until Clear_All.
